// File: rtl/sram_ctrl.sv
// Request/response controller for an asynchronous SRAM: SETUP/ACCESS/HOLD strobe timing.
// Optional byte-enable read-modify-write support under SRAM_CTRL_BYTE_WE_EN.
module sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_CTRL_BYTE_WE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_cs_n,
  output logic              sram_wr_n,
  output logic              sram_rd_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_oe
);

  localparam int BE_W = DATA_W / 8;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state, nx_state;
  logic [3:0]        cnt, nx_cnt;
  logic              we_q, nx_we;
  logic              rmw_q, nx_rmw;
  logic [DATA_W-1:0] wdata_q, nx_wdata;
  logic [BE_W-1:0]   be_q, nx_be;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] merged;

  logic              nx_ready, nx_resp_valid;
  logic [DATA_W-1:0] nx_resp_rdata, nx_dout;
  logic              nx_cs_n, nx_wr_n, nx_rd_n, nx_oe;
  logic [ADDR_W-1:0] nx_addr;

`ifdef SRAM_CTRL_BYTE_WE_EN
  assign be = req_be;
`else
  assign be = '1;
`endif

  // Enabled bytes from the request, the rest from the word just read.
  always_comb begin
    merged = sram_din;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  always_comb begin
    nx_state      = state;
    nx_cnt        = cnt;
    nx_we         = we_q;
    nx_rmw        = rmw_q;
    nx_wdata      = wdata_q;
    nx_be         = be_q;
    nx_ready      = 1'b0;
    nx_resp_valid = 1'b0;
    nx_resp_rdata = resp_rdata;
    nx_cs_n       = sram_cs_n;
    nx_wr_n       = sram_wr_n;
    nx_rd_n       = sram_rd_n;
    nx_addr       = sram_addr;
    nx_dout       = sram_dout;
    nx_oe         = sram_oe;
    unique case (state)
      IDLE: begin
        if (rmw_q) begin
          // Turnaround cycle, then the write half of the RMW.
          nx_state = SETUP;
          nx_cs_n  = 1'b0;
          nx_oe    = 1'b1;
          nx_dout  = wdata_q;
          nx_we    = 1'b1;
          nx_rmw   = 1'b0;
        end else begin
          nx_ready = 1'b1;
          if (req_valid && req_ready) begin
            nx_wdata = req_wdata;
            nx_be    = be;
            if (req_we && be == '0) begin
              nx_resp_valid = 1'b1;
            end else begin
              nx_ready = 1'b0;
              nx_state = SETUP;
              nx_cs_n  = 1'b0;
              nx_addr  = req_addr;
              nx_we    = req_we && (&be);
              nx_rmw   = req_we && !(&be);
              nx_oe    = req_we && (&be);
              if (req_we && (&be)) nx_dout = req_wdata;
            end
          end
        end
      end
      SETUP: begin
        nx_state = ACCESS;
        nx_cnt   = 4'(WAIT_CYCLES - 1);
        if (we_q) nx_wr_n = 1'b0;
        else      nx_rd_n = 1'b0;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          nx_state = HOLD;
          nx_wr_n  = 1'b1;
          nx_rd_n  = 1'b1;
          if (rmw_q) begin
            nx_wdata = merged;
          end else begin
            nx_resp_valid = 1'b1;
            if (!we_q) nx_resp_rdata = sram_din;
          end
        end else begin
          nx_cnt = cnt - 4'd1;
        end
      end
      HOLD: begin
        nx_state = IDLE;
        nx_cs_n  = 1'b1;
        nx_oe    = 1'b0;
        nx_ready = !rmw_q;
      end
      default: nx_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      rmw_q      <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      sram_cs_n  <= 1'b1;
      sram_wr_n  <= 1'b1;
      sram_rd_n  <= 1'b1;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_oe    <= 1'b0;
    end else begin
      state      <= nx_state;
      cnt        <= nx_cnt;
      we_q       <= nx_we;
      rmw_q      <= nx_rmw;
      wdata_q    <= nx_wdata;
      be_q       <= nx_be;
      req_ready  <= nx_ready;
      resp_valid <= nx_resp_valid;
      resp_rdata <= nx_resp_rdata;
      sram_cs_n  <= nx_cs_n;
      sram_wr_n  <= nx_wr_n;
      sram_rd_n  <= nx_rd_n;
      sram_addr  <= nx_addr;
      sram_dout  <= nx_dout;
      sram_oe    <= nx_oe;
    end
  end

endmodule
